// File: rtl/sys_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_pkg
// Description : Shared types and constants for the system-bus decoder.
//               FSM state encoding, default region-field position,
//               error codes and an address-to-region helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int c_SEL_LSB = 20;
  localparam int c_SEL_W   = 3;

  // Error flag values reported with sys_ack_o for the two decoder-generated errors
  localparam logic c_ERR_UNMAPPED = 1'b1;
  localparam logic c_ERR_TIMEOUT  = 1'b1;

  // Region field of an address, using the default field position
  function automatic logic [c_SEL_W-1:0] region_of(input logic [31:0] addr);
    return addr[c_SEL_LSB +: c_SEL_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_watchdog
// Description : Saturating cycle counter with load/clear/increment controls
//               and a timeout flag raised once the count reaches MAX_CYC.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_load    - load the counter with 1
//               i_clr     - clear the counter to 0
//               i_inc     - increment (saturates, never wraps)
//               o_timeout - count >= MAX_CYC
// Revision    : 1.0 - initial release
// ============================================================================
module sys_bus_watchdog #(
  parameter int MAX_CYC = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam int c_CW = $clog2(MAX_CYC + 1);

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_CW'(1);
    end else if (i_inc && (r_count != {c_CW{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = (r_count >= c_CW'(MAX_CYC));

endmodule
`default_nettype wire

// File: rtl/sys_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_decoder
// Description : Decodes the region field of a single-outstanding sys_* request
//               and forwards it to one of NS slaves. Returns one registered
//               ack with read data and error. Unmapped regions and slaves
//               that do not answer within TO_CYC cycles get an error ack.
// Ports       : sys_clk_i / sys_rst_i        - clock, sync active-high reset
//               sys_addr_i/wdata_i/sel_i      - request address, data, byte sel
//               sys_wen_i / sys_ren_i         - write / read request pulses
//               sys_rdata_o/err_o/ack_o       - completion (one-cycle ack)
//               sub_addr_o/wdata_o/sel_o      - latched request, shared by slaves
//               sub_wen_o / sub_ren_o         - one-hot per-slave pulses
//               sub_rdata_i/err_i/ack_i       - per-slave responses
//               overrun_o                     - sticky: request seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module sys_bus_decoder
  import sys_bus_pkg::*;
#(
  parameter int                       DW      = 32,
  parameter int                       AW      = 32,
  parameter int                       NS      = 8,
  parameter int                       SEL_LSB = 20,
  parameter int                       SEL_W   = 3,
  parameter logic [(1<<SEL_W)-1:0]    EN_MASK = 8'hFF,
  parameter int                       TO_CYC  = 24
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic [AW-1:0]      sys_addr_i,
  input  logic [DW-1:0]      sys_wdata_i,
  input  logic [DW/8-1:0]    sys_sel_i,
  input  logic               sys_wen_i,
  input  logic               sys_ren_i,
  output logic [DW-1:0]      sys_rdata_o,
  output logic               sys_err_o,
  output logic               sys_ack_o,
  output logic [AW-1:0]      sub_addr_o,
  output logic [DW-1:0]      sub_wdata_o,
  output logic [DW/8-1:0]    sub_sel_o,
  output logic [NS-1:0]      sub_wen_o,
  output logic [NS-1:0]      sub_ren_o,
  input  logic [NS*DW-1:0]   sub_rdata_i,
  input  logic [NS-1:0]      sub_err_i,
  input  logic [NS-1:0]      sub_ack_i,
  output logic               overrun_o
);

  localparam int c_NREG = 1 << SEL_W;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW/8-1:0]     r_sel;
  logic [SEL_W-1:0]    r_region;
  logic                r_is_wr;
  logic [NS-1:0]       r_sub_wen;
  logic [NS-1:0]       r_sub_ren;
  logic                r_ack;
  logic                r_err;
  logic [DW-1:0]       r_rdata;
  logic                r_overrun;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0]    w_region;
  logic                w_req;
  logic                w_mapped;
  logic [c_NREG-1:0]   w_map;
  logic [NS-1:0]       w_req_oh;
  logic [NS-1:0]       w_cur_oh;

  assign w_region = sys_addr_i[SEL_LSB +: SEL_W];
  assign w_req    = sys_wen_i | sys_ren_i;

  // Constant table: region r is usable only if it has a slave and is enabled
  for (genvar g = 0; g < c_NREG; g++) begin : g_map
    if (g < NS) begin : g_real
      assign w_map[g] = EN_MASK[g];
    end else begin : g_none
      assign w_map[g] = 1'b0;
    end
  end

  assign w_mapped = w_map[w_region];

  // One-hot of the incoming region and of the latched (active) region
  for (genvar g = 0; g < NS; g++) begin : g_onehot
    assign w_req_oh[g] = (w_region == SEL_W'(g));
    assign w_cur_oh[g] = (r_region == SEL_W'(g));
  end

  // --------------------------------------------------------------------------
  // Response mux: only the active slave is looked at, so acks from the
  // others are ignored without any extra state.
  // --------------------------------------------------------------------------
  logic              w_sel_ack;
  logic              w_sel_err;
  logic [DW-1:0]     w_sel_rdata;
  logic [DW-1:0]     w_rd_term [NS];

  assign w_sel_ack = |(sub_ack_i & w_cur_oh);
  assign w_sel_err = |(sub_err_i & sub_ack_i & w_cur_oh);

  for (genvar g = 0; g < NS; g++) begin : g_rdmux
    assign w_rd_term[g] = w_cur_oh[g] ? sub_rdata_i[g*DW +: DW] : '0;
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      w_sel_rdata = w_sel_rdata | w_rd_term[s];
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog: loaded in REQ, counts in WAIT, cleared whenever idle
  // --------------------------------------------------------------------------
  logic w_wd_load;
  logic w_wd_clr;
  logic w_wd_inc;
  logic w_wd_timeout;

  assign w_wd_load = (r_state == REQ);
  assign w_wd_clr  = (r_state == IDLE);
  assign w_wd_inc  = (r_state == WAIT) && !w_wd_timeout;

  sys_bus_watchdog #(
    .MAX_CYC (TO_CYC)
  ) u_watchdog (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .i_load    (w_wd_load),
    .i_clr     (w_wd_clr),
    .i_inc     (w_wd_inc),
    .o_timeout (w_wd_timeout)
  );

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_region  <= '0;
      r_is_wr   <= 1'b0;
      r_sub_wen <= '0;
      r_sub_ren <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below
      r_sub_wen <= '0;
      r_sub_ren <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;

      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr   <= sys_addr_i;
            r_wdata  <= sys_wdata_i;
            r_sel    <= sys_sel_i;
            r_region <= w_region;
            // Write wins over a simultaneous read
            r_is_wr  <= sys_wen_i;
            if (w_mapped) begin
              r_state <= REQ;
              if (sys_wen_i) begin
                r_sub_wen <= w_req_oh;
              end else begin
                r_sub_ren <= w_req_oh;
              end
            end else begin
              r_ack <= 1'b1;
              r_err <= c_ERR_UNMAPPED;
            end
          end
        end

        REQ, WAIT: begin
          // Single outstanding: anything arriving now is dropped
          if (w_req) begin
            r_overrun <= 1'b1;
          end
          if (w_sel_ack) begin
            r_ack   <= 1'b1;
            r_err   <= w_sel_err;
            r_rdata <= r_is_wr ? '0 : w_sel_rdata;
            r_state <= IDLE;
          end else if ((r_state == WAIT) && w_wd_timeout) begin
            r_ack   <= 1'b1;
            r_err   <= c_ERR_TIMEOUT;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sys_rdata_o = r_rdata;
  assign sys_err_o   = r_err;
  assign sys_ack_o   = r_ack;
  assign sub_addr_o  = r_addr;
  assign sub_wdata_o = r_wdata;
  assign sub_sel_o   = r_sel;
  assign sub_wen_o   = r_sub_wen;
  assign sub_ren_o   = r_sub_ren;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire
